// File: rtl/exec_muldiv_pkg.sv
// exec_muldiv_pkg: shared funct3 codes, FSM encoding and constants for the
// iterative RV32M multiply/divide unit.
package exec_muldiv_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

    localparam int          MD_ITER = 32;
    localparam logic [31:0] MD_DIV0 = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        MD_ST_IDLE = 3'd0,
        MD_ST_MUL  = 3'd1,
        MD_ST_DIV  = 3'd2,
        MD_ST_FIX  = 3'd3,
        MD_ST_DONE = 3'd4
    } md_state_t;

    function automatic logic md_op1_signed(input logic [2:0] f3);
        return f3 == MULDIV_OP_MULH || f3 == MULDIV_OP_MULHSU ||
               f3 == MULDIV_OP_DIV  || f3 == MULDIV_OP_REM;
    endfunction

    function automatic logic md_op2_signed(input logic [2:0] f3);
        return f3 == MULDIV_OP_MULH || f3 == MULDIV_OP_DIV || f3 == MULDIV_OP_REM;
    endfunction

endpackage

// File: rtl/exec_muldiv_div_restore_step.sv
// div_restore_step: one combinational restoring-division iteration
// (shift in a dividend bit, subtract the divisor if it fits).
module div_restore_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q
);
    logic [XLEN:0]   w_sh;
    logic [XLEN-1:0] w_diff;

    assign w_sh   = {i_rem, i_bit};
    // When the divisor fits, the true difference is below the divisor, so XLEN bits suffice.
    assign w_diff = w_sh[XLEN-1:0] - i_div;
    assign o_q    = w_sh >= {1'b0, i_div};
    assign o_rem  = o_q ? w_diff : w_sh[XLEN-1:0];

endmodule

// File: rtl/exec_muldiv.sv
// exec_muldiv: multi-cycle RV32M unit (shift-add multiplier, restoring divider).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module exec_muldiv
    import exec_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    md_state_t       r_state, w_next;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_a, r_b, r_rem, r_result;
    logic [4:0]      r_cnt;
    logic            r_neg, r_rneg;
    logic            w_accept, w_n1, w_n2, w_is_div, w_div0, w_ovf, w_short, w_q;
    logic [XLEN-1:0] w_m1, w_m2, w_spec_res, w_short_res, w_rem_nx, w_quo, w_remf, w_fix;

    assign w_accept   = (r_state == MD_ST_IDLE || r_state == MD_ST_DONE) && start && !flush;
    assign w_n1       = md_op1_signed(funct3) & op1[XLEN-1];
    assign w_n2       = md_op2_signed(funct3) & op2[XLEN-1];
    assign w_m1       = w_n1 ? -op1 : op1;
    assign w_m2       = w_n2 ? -op2 : op2;
    assign w_is_div   = funct3[2];
    assign w_div0     = w_is_div && op2 == '0;
    assign w_ovf      = w_is_div && !funct3[0] && op1 == {1'b1, {(XLEN-1){1'b0}}} && op2 == '1;
    // Overflow DIV returns the dividend itself (0x80000000).
    assign w_spec_res = w_div0 ? (funct3[1] ? op1 : MD_DIV0) : (funct3[1] ? '0 : op1);
    assign w_quo      = r_neg ? -r_a : r_a;
    assign w_remf     = r_rneg ? -r_rem : r_rem;

    div_restore_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_bit (r_a[XLEN-1]),
        .i_div (r_b),
        .o_rem (w_rem_nx),
        .o_q   (w_q)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fprod;
    assign w_fprod     = $signed({{XLEN{w_n1 | (md_op1_signed(funct3) & op1[XLEN-1])}}, op1}) *
                         $signed({{XLEN{w_n2 | (md_op2_signed(funct3) & op2[XLEN-1])}}, op2});
    assign w_short     = w_div0 || w_ovf || !w_is_div;
    assign w_short_res = w_is_div ? w_spec_res
                       : (funct3 == MULDIV_OP_MUL ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN]);
    assign w_fix       = r_f3[1] ? w_remf : w_quo;
`else
    logic [2*XLEN-1:0] r_acc, w_prod;
    logic [XLEN:0]     w_sum;
    // Low half of the accumulator starts as the multiplier and shifts out one bit per step.
    assign w_sum       = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_acc[0] ? r_a : '0};
    assign w_prod      = r_neg ? -r_acc : r_acc;
    assign w_short     = w_div0 || w_ovf;
    assign w_short_res = w_spec_res;
    assign w_fix       = r_f3[2] ? (r_f3[1] ? w_remf : w_quo)
                       : (r_f3 == MULDIV_OP_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MD_ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_ST_IDLE, MD_ST_DONE: w_next = !w_accept ? MD_ST_IDLE : w_short ? MD_ST_DONE
                                           : w_is_div ? MD_ST_DIV : MD_ST_MUL;
            MD_ST_MUL, MD_ST_DIV:   w_next = r_cnt == 5'(MD_ITER-1) ? MD_ST_FIX : r_state;
            MD_ST_FIX:              w_next = MD_ST_DONE;
            default:                w_next = MD_ST_IDLE;
        endcase
        if (flush) w_next = MD_ST_IDLE;
    end

    always_comb begin
        busy   = r_state == MD_ST_MUL || r_state == MD_ST_DIV || r_state == MD_ST_FIX;
        done   = r_state == MD_ST_DONE;
        result = r_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f3     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
`ifndef MULDIV_FAST_MUL_EN
            r_acc    <= '0;
`endif
        end else if (!flush) begin
            if (w_accept) begin
                r_f3   <= funct3;
                r_a    <= w_m1;
                r_b    <= w_m2;
                r_rem  <= '0;
                r_cnt  <= '0;
                r_neg  <= w_n1 ^ w_n2;
                r_rneg <= w_n1;
`ifndef MULDIV_FAST_MUL_EN
                r_acc  <= {{XLEN{1'b0}}, w_m2};
`endif
                if (w_short) r_result <= w_short_res;
            end else if (r_state == MD_ST_DIV) begin
                r_cnt <= r_cnt + 1'b1;
                r_rem <= w_rem_nx;
                r_a   <= {r_a[XLEN-2:0], w_q};
`ifndef MULDIV_FAST_MUL_EN
            end else if (r_state == MD_ST_MUL) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= {w_sum, r_acc[XLEN-1:1]};
`endif
            end else if (r_state == MD_ST_FIX) begin
                r_result <= w_fix;
            end
        end
    end

endmodule

// File: tb/tb_exec_muldiv.sv
// tb_exec_muldiv: randomized and directed bench for exec_muldiv, checked every
// cycle against a 64-bit arithmetic reference model of RV32M semantics.
module tb_exec_muldiv;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        busy, done;
    logic [31:0] result;

    int          cyc = 0, checks = 0, failures = 0;
    int          acc_c = -100, done_c = -100;
    logic [31:0] exp_res = '0, held = '0;
    bit          chk_en = 1'b0;

    exec_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        logic [63:0] p;
        bit ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        bit eb, ed;
        if (chk_en && rst_n) begin
            ed = cyc == done_c;
            eb = cyc > acc_c && cyc < done_c;
            chk("busy", {31'b0, busy}, {31'b0, eb});
            chk("done", {31'b0, done}, {31'b0, ed});
            if (ed) held = exp_res;
            chk("result", result, held);
        end
    end

    task automatic wait_until(input int t);
        for (int n = 0; cyc < t && n < 200; n++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        acc_c  = cyc - 1;
        done_c = acc_c + lat(f, a, b);
        exp_res = ref_op(f, a, b);
    endtask

    task automatic directed(input string nm, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] lit);
        chk({"model_", nm}, ref_op(f, a, b), lit);
        issue(f, a, b);
        wait_until(done_c + 1);
        chk(nm, result, lit);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        directed("mul",    3'd0, 32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        directed("mulh",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0);
        directed("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        directed("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        directed("div",    3'd4, 32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFD);
        directed("rem",    3'd6, 32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFF);
        directed("divu",   3'd5, 32'd100,        32'd7,         32'd14);
        directed("remu",   3'd7, 32'd100,        32'd7,         32'd2);
        directed("div0",   3'd4, 32'd5,          32'h0,         32'hFFFF_FFFF);
        directed("remu0",  3'd7, 32'd5,          32'h0,         32'd5);
        directed("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        directed("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0);
        // kill a DIV in its tenth cycle; result must keep the previous value
        issue(3'd4, 32'd1000, 32'd3);
        wait_until(acc_c + 10);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        acc_c = -100;
        done_c = -100;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        chk("flush_result", result, 32'h0);
        directed("after_flush", 3'd4, 32'd1000, 32'd3, 32'd333);
        // back-to-back accept in the DONE cycle, plus ignored start pulses while busy
        issue(3'd5, 32'd100, 32'd7);
        wait_until(done_c);
        issue(3'd7, 32'd100, 32'd7);
        if (done_c - acc_c > 3) begin
            wait_until(acc_c + 3);
            funct3 = 3'd0; op1 = $urandom; op2 = $urandom; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_until(done_c + 1);
        chk("b2b_remu", result, 32'd2);
        for (int i = 0; i < 60; i++) begin
            logic [2:0] f;
            f = 3'($urandom_range(0, 7));
            issue(f, pick(), pick());
            if (done_c - acc_c > 3 && $urandom % 3 == 0) begin
                wait_until(acc_c + 1 + int'($urandom % (done_c - acc_c - 2)));
                funct3 = 3'($urandom); op1 = $urandom; op2 = $urandom; start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if ($urandom % 4 == 0) wait_until(done_c);
            else                   wait_until(done_c + 1);
        end
        wait_until(done_c + 1);
        // asynchronous reset in the middle of a multiply
        issue(3'd0, 32'd123, 32'd456);
        wait_until(acc_c + 6);
        #2;
        rst_n = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_done", {31'b0, done}, 32'h0);
        chk("arst_result", result, 32'h0);
        held = '0;
        acc_c = -100;
        done_c = -100;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        directed("after_rst", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'h3);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
